ysyx_040750_if_id_queue: RTL and testbench
==========================================

Name: ysyx_040750_if_id_queue

Overview:
- Decoupling buffer between the IF stage (PC/fetch) and the ID stage of the full-pipeline core.
- Accepts {pc, inst} pairs under IF's valid/allowin handshake and holds up to DEPTH entries in FIFO order.
- Presents the head entry to ID under ID's valid/allowin handshake.
- Discards all held entries on a pipeline flush (branch/jump redirect, fence.i).

Parameters:
- DEPTH, 2, number of entries; power of two, >= 2.
- PTR_W, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- I_sys_clk  input  1  clock
- I_rst  input  1  reset
- I_IF_valid  input  1  IF presents a valid {pc, inst}
- I_pc  input  32  PC of the presented instruction
- I_inst  input  32  presented instruction word
- O_IF_ID_allowin  output  1  queue can accept an entry this cycle
- I_ID_allowin  input  1  ID consumes the head entry this cycle if O_ID_valid
- O_ID_valid  output  1  head entry valid
- O_pc  output  32  head entry PC
- O_inst  output  32  head entry instruction
- I_flush  input  1  discard all entries (redirect)
- O_count  output  PTR_W+1  current occupancy

Behaviour:
- Clock and reset: clock I_sys_clk; reset I_rst, synchronous, active-high.
- Reset state: rd_ptr=0, wr_ptr=0, count=0, all entry storage = 0.
  - Resulting outputs: O_ID_valid=0, O_IF_ID_allowin=1, O_pc=0, O_inst=0, O_count=0.
- Push: push = I_IF_valid && O_IF_ID_allowin && !I_flush.
  - On push, entry[wr_ptr] <= {I_pc, I_inst}; wr_ptr <= wr_ptr+1, wrapping modulo DEPTH.
- Pop: pop = O_ID_valid && I_ID_allowin && !I_flush; on pop, rd_ptr <= rd_ptr+1, wrapping modulo DEPTH.
- count update:
  - +1 on push only, -1 on pop only.
  - Unchanged on simultaneous push+pop. Legal at any non-full, non-empty occupancy, and when empty? No: when empty, pop=0.
- O_IF_ID_allowin = (count != DEPTH).
  - Depends only on registered state, so there is no combinational path from I_ID_allowin to IF.
  - When full, IF is stalled even if ID pops in the same cycle; the slot frees on the next cycle.
- O_ID_valid = (count != 0).
- O_pc/O_inst = entry[rd_ptr], combinational read of registered storage.
  - When empty they show stale contents; ID qualifies them with O_ID_valid.
- Latency: an entry pushed in cycle N is visible with O_ID_valid=1 in cycle N+1. There is no same-cycle bypass.
- Throughput: 1 entry/cycle sustained when ID always allows in.
- Flush:
  - I_flush=1 in cycle N sets rd_ptr, wr_ptr and count to 0 at edge N+1.
  - Any same-cycle push and pop are suppressed.
  - Entry storage is not cleared.
  - O_ID_valid=0 and O_IF_ID_allowin=1 in cycle N+1.
- Flush and reset together: reset dominates; the result is identical either way.
- Storage holds its value whenever no push occurs. Pointers and count hold whenever there is no push, pop or flush.
- Illegal: I_IF_valid must hold I_pc/I_inst stable until accepted; the queue does not check this.

Optional Feature:
- Macro: YSYX_040750_IFQ_PREDECODE_EN.
- Defined:
  - Each entry stores one extra bit, is_ctrl, computed at push from I_inst[6:0] ∈ {7'b1101111 (jal), 7'b1100111 (jalr), 7'b1100011 (branch)}.
  - Extra output port O_is_ctrl (1 bit) = entry[rd_ptr].is_ctrl; reset value 0.
  - All other behaviour is unchanged.
- Undefined: the port and the storage bit do not exist.

Test Plan:
- Reset, then one push: assert I_rst 2 cycles, then push pc=0x30000000 inst=0x00000013.
  - Cycle after reset: O_ID_valid=0, O_IF_ID_allowin=1, O_count=0.
  - Cycle after push: O_ID_valid=1, O_pc=0x30000000, O_inst=0x00000013, O_count=1.
- Fill and stall, DEPTH=2, I_ID_allowin=0: push pc 0x30000000, 0x30000004.
  - O_count=2, O_IF_ID_allowin=0.
  - A third I_IF_valid with pc 0x30000008 is not accepted.
  - Raise I_ID_allowin: O_pc sequence is 0x30000000, 0x30000004, then 0x30000008.
- Streaming: I_IF_valid=1 and I_ID_allowin=1 every cycle for 8 cycles, pc incrementing by 4 from 0x30000000.
  - O_count stays 1 after the first cycle.
  - ID sees 8 consecutive pcs with no bubbles.
  - Pointers wrap without loss or reorder.
- Flush:
  - With 2 entries held, assert I_flush with I_IF_valid=1 (pc 0x30000010) and I_ID_allowin=1.
  - Next cycle: O_count=0, O_ID_valid=0, O_IF_ID_allowin=1.
  - pc 0x30000010 is never delivered.
- Flush with reset: assert I_flush and I_rst together; the next cycle matches the reset state exactly.
- Predecode (macro defined):
  - Push inst 0x0000006F (jal) then 0x00000013.
  - Head O_is_ctrl=1, then 0 after the pop.

Source files
------------

// File: rtl/ysyx_040750_if_id_queue.sv
// ----------------------------------------------------------------------------
// ysyx_040750_if_id_queue
//   FIFO buffer decoupling the IF stage from the ID stage. IF pushes {pc, inst}
//   pairs under a valid/allowin handshake; ID consumes the head entry under its
//   own valid/allowin handshake. A flush (redirect, fence.i) drops everything
//   held.
//
//   Ports:
//     I_sys_clk        clock
//     I_rst            synchronous active-high reset
//     I_IF_valid       IF presents a valid {I_pc, I_inst}
//     I_pc, I_inst     presented PC / instruction word
//     O_IF_ID_allowin  queue can accept an entry this cycle (registered state only)
//     I_ID_allowin     ID takes the head entry this cycle if O_ID_valid
//     O_ID_valid       head entry valid
//     O_pc, O_inst     head entry (stale when empty)
//     I_flush          discard all entries
//     O_count          occupancy
//     O_is_ctrl        head entry is jal/jalr/branch (only with predecode)
//
//   Optional feature macro: YSYX_040750_IFQ_PREDECODE_EN adds a per-entry
//   is_ctrl bit computed from the opcode at push time and the O_is_ctrl port.
// ----------------------------------------------------------------------------
module ysyx_040750_if_id_queue #(
   parameter int DEPTH = 2,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic             I_sys_clk,
   input  logic             I_rst,
   input  logic             I_IF_valid,
   input  logic [31:0]      I_pc,
   input  logic [31:0]      I_inst,
   output logic             O_IF_ID_allowin,
   input  logic             I_ID_allowin,
   output logic             O_ID_valid,
   output logic [31:0]      O_pc,
   output logic [31:0]      O_inst,
   input  logic             I_flush,
`ifdef YSYX_040750_IFQ_PREDECODE_EN
   output logic             O_is_ctrl,
`endif
   output logic [PTR_W:0]   O_count
);

   localparam logic [PTR_W:0]   FULL    = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W:0]   count;
   logic [31:0]      pc_mem   [DEPTH];
   logic [31:0]      inst_mem [DEPTH];
   logic             push;
   logic             pop;

   // allowin looks only at registered count, so ID's allowin never reaches IF
   // combinationally; a full queue stalls IF even on a same-cycle pop.
   assign O_IF_ID_allowin = (count != FULL);
   assign O_ID_valid      = (count != '0);
   assign O_count         = count;
   assign O_pc            = pc_mem[rd_ptr];
   assign O_inst          = inst_mem[rd_ptr];

   assign push = I_IF_valid && O_IF_ID_allowin && !I_flush;
   assign pop  = O_ID_valid && I_ID_allowin && !I_flush;

   always_ff @(posedge I_sys_clk) begin
      if (I_rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            pc_mem[i]   <= '0;
            inst_mem[i] <= '0;
         end
      end else if (I_flush) begin
         // storage is intentionally left untouched; only the bookkeeping resets
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            pc_mem[wr_ptr]   <= I_pc;
            inst_mem[wr_ptr] <= I_inst;
            wr_ptr           <= wr_ptr + PTR_ONE;  // DEPTH is a power of two: wraps naturally
         end
         if (pop)
            rd_ptr <= rd_ptr + PTR_ONE;
         case ({push, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

`ifdef YSYX_040750_IFQ_PREDECODE_EN
   logic ctrl_mem [DEPTH];
   logic in_is_ctrl;

   // jal, jalr, conditional branch
   assign in_is_ctrl = (I_inst[6:0] == 7'b1101111) ||
                       (I_inst[6:0] == 7'b1100111) ||
                       (I_inst[6:0] == 7'b1100011);
   assign O_is_ctrl  = ctrl_mem[rd_ptr];

   always_ff @(posedge I_sys_clk) begin
      if (I_rst) begin
         for (int i = 0; i < DEPTH; i++)
            ctrl_mem[i] <= 1'b0;
      end else if (push) begin
         ctrl_mem[wr_ptr] <= in_is_ctrl;
      end
   end
`endif

endmodule

// File: tb/tb_ysyx_040750_if_id_queue.sv
module tb_ysyx_040750_if_id_queue;
   localparam int DEPTH = 2;
   localparam int PTR_W = $clog2(DEPTH);

   logic             clk = 1'b0;
   logic             rst;
   logic             if_valid;
   logic [31:0]      pc_in;
   logic [31:0]      inst_in;
   logic             if_allowin;
   logic             id_allowin;
   logic             id_valid;
   logic [31:0]      pc_out;
   logic [31:0]      inst_out;
   logic             flush;
   logic [PTR_W:0]   count;
`ifdef YSYX_040750_IFQ_PREDECODE_EN
   logic             is_ctrl;
`endif

   int checks = 0;
   int errors = 0;

   // reference model: a plain queue of {pc, inst}
   logic [63:0] mq[$];

   always #5 clk = ~clk;

   ysyx_040750_if_id_queue #(.DEPTH(DEPTH)) dut (
      .I_sys_clk(clk),
      .I_rst(rst),
      .I_IF_valid(if_valid),
      .I_pc(pc_in),
      .I_inst(inst_in),
      .O_IF_ID_allowin(if_allowin),
      .I_ID_allowin(id_allowin),
      .O_ID_valid(id_valid),
      .O_pc(pc_out),
      .O_inst(inst_out),
      .I_flush(flush),
`ifdef YSYX_040750_IFQ_PREDECODE_EN
      .O_is_ctrl(is_ctrl),
`endif
      .O_count(count)
   );

   function automatic logic model_ctrl(input logic [31:0] inst);
      return inst[6:0] inside {7'h6F, 7'h67, 7'h63};
   endfunction

   // advance one clock and apply the same cycle to the model
   task automatic tick();
      bit do_push, do_pop;
      do_push = if_valid && (mq.size() < DEPTH) && !flush;
      do_pop  = (mq.size() != 0) && id_allowin && !flush;
      @(posedge clk);
      if (rst || flush) mq.delete();
      else begin
         if (do_pop)  void'(mq.pop_front());
         if (do_push) mq.push_back({pc_in, inst_in});
      end
      #1;
   endtask

   task automatic idle_inputs();
      if_valid = 0; id_allowin = 0; flush = 0; pc_in = 0; inst_in = 0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1; tick(); tick(); rst = 0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (id_valid !== 1'b0 || if_allowin !== 1'b1 || count !== '0 || pc_out !== 32'h0 || inst_out !== 32'h0) begin
         errors++;
         $display("FAIL reset_state: valid=%b allowin=%b count=%0d pc=%h inst=%h want 0 1 0 0 0",
                  id_valid, if_allowin, count, pc_out, inst_out);
      end
      if_valid = 1; pc_in = 32'h3000_0000; inst_in = 32'h0000_0013;
      tick();
      if_valid = 0;
      checks++;
      if (id_valid !== 1'b1 || pc_out !== 32'h3000_0000 || inst_out !== 32'h0000_0013 || count !== 1) begin
         errors++;
         $display("FAIL first_push: valid=%b pc=%h inst=%h count=%0d want 1 30000000 00000013 1",
                  id_valid, pc_out, inst_out, count);
      end
   endtask

   task automatic test_fill_stall();
      logic [31:0] seen[$];
      do_reset();
      for (int i = 0; i < 2; i++) begin
         if_valid = 1; pc_in = 32'h3000_0000 + 4*i; inst_in = 32'h13 + 32'(i << 7);
         tick();
      end
      checks++;
      if (count !== 2 || if_allowin !== 1'b0) begin
         errors++;
         $display("FAIL fill_full: count=%0d allowin=%b want 2 0", count, if_allowin);
      end
      pc_in = 32'h3000_0008; inst_in = 32'h0000_0093;
      tick();
      checks++;
      if (count !== 2 || pc_out !== 32'h3000_0000) begin
         errors++;
         $display("FAIL stall_hold: count=%0d head=%h want 2 30000000", count, pc_out);
      end
      id_allowin = 1;
      for (int c = 0; c < 10 && seen.size() < 3; c++) begin
         bit acc;
         if (id_valid) seen.push_back(pc_out);
         acc = if_valid && if_allowin;
         tick();
         if (acc) if_valid = 0;
      end
      id_allowin = 0;
      checks++;
      if (seen.size() != 3 || seen[0] !== 32'h3000_0000 || seen[1] !== 32'h3000_0004 || seen[2] !== 32'h3000_0008) begin
         errors++;
         $display("FAIL drain_order: got %0d pcs %p want 30000000 30000004 30000008", seen.size(), seen);
      end
   endtask

   task automatic test_streaming();
      logic [31:0] seen[$];
      int bubbles = 0;
      int bad_cnt = 0;
      do_reset();
      id_allowin = 1;
      for (int i = 0; i < 9; i++) begin
         if_valid = (i < 8);
         pc_in    = 32'h3000_0000 + 32'(4*i);
         inst_in  = 32'h0000_0013 | 32'(i << 20);
         if (count !== ((i == 0) ? 0 : 1)) bad_cnt++;
         if (i > 0 && !id_valid) bubbles++;
         if (id_valid) seen.push_back(pc_out);
         tick();
      end
      idle_inputs();
      checks++;
      if (bad_cnt != 0 || bubbles != 0) begin
         errors++;
         $display("FAIL stream_steady: bad_count_cycles=%0d bubbles=%0d want 0 0", bad_cnt, bubbles);
      end
      checks++;
      if (seen.size() != 8) begin
         errors++;
         $display("FAIL stream_len: delivered=%0d want 8", seen.size());
      end else begin
         for (int i = 0; i < 8; i++)
            if (seen[i] !== 32'h3000_0000 + 32'(4*i)) begin
               errors++;
               $display("FAIL stream_order: idx %0d pc=%h want %h", i, seen[i], 32'h3000_0000 + 32'(4*i));
               break;
            end
      end
   endtask

   task automatic test_flush();
      int leaked = 0;
      do_reset();
      for (int i = 0; i < 2; i++) begin
         if_valid = 1; pc_in = 32'h3000_0000 + 4*i; inst_in = 32'h13;
         tick();
      end
      flush = 1; if_valid = 1; pc_in = 32'h3000_0010; id_allowin = 1;
      tick();
      flush = 0; if_valid = 0;
      checks++;
      if (count !== 0 || id_valid !== 1'b0 || if_allowin !== 1'b1) begin
         errors++;
         $display("FAIL flush_clear: count=%0d valid=%b allowin=%b want 0 0 1", count, id_valid, if_allowin);
      end
      for (int i = 0; i < 4; i++) begin
         if (id_valid && pc_out === 32'h3000_0010) leaked++;
         tick();
      end
      id_allowin = 0;
      checks++;
      if (leaked != 0 || count !== 0) begin
         errors++;
         $display("FAIL flush_no_deliver: leaked=%0d count=%0d want 0 0", leaked, count);
      end
   endtask

   task automatic test_flush_reset();
      do_reset();
      if_valid = 1; pc_in = 32'h3000_0040; inst_in = 32'h0000_006F;
      tick();
      pc_in = 32'h3000_0044; inst_in = 32'h0000_0113;
      tick();
      rst = 1; flush = 1;
      tick();
      rst = 0; flush = 0; if_valid = 0;
      checks++;
      if (id_valid !== 1'b0 || if_allowin !== 1'b1 || count !== '0 || pc_out !== 32'h0 || inst_out !== 32'h0) begin
         errors++;
         $display("FAIL flush_reset: valid=%b allowin=%b count=%0d pc=%h inst=%h want 0 1 0 0 0",
                  id_valid, if_allowin, count, pc_out, inst_out);
      end
`ifdef YSYX_040750_IFQ_PREDECODE_EN
      checks++;
      if (is_ctrl !== 1'b0) begin
         errors++;
         $display("FAIL flush_reset_ctrl: is_ctrl=%b want 0", is_ctrl);
      end
`endif
   endtask

   task automatic test_random();
      int bad = 0;
      do_reset();
      for (int c = 0; c < 400; c++) begin
         bit acc;
         // hold pc/inst while an offer is pending
         if (!if_valid) begin
            if_valid = ($urandom_range(0, 3) != 0);
            pc_in    = $urandom();
            inst_in  = $urandom();
            if ($urandom_range(0, 3) == 0) inst_in[6:0] = 7'h63;
         end
         id_allowin = ($urandom_range(0, 2) != 0);
         flush      = ($urandom_range(0, 24) == 0);
         checks++;
         if (id_valid !== (mq.size() != 0) || if_allowin !== (mq.size() != DEPTH) ||
             count !== (PTR_W+1)'(mq.size()) ||
             (mq.size() != 0 && (pc_out !== mq[0][63:32] || inst_out !== mq[0][31:0]))) begin
            errors++; bad++;
            if (bad < 5)
               $display("FAIL random_cycle%0d: valid=%b allowin=%b count=%0d pc=%h inst=%h want occupancy %0d",
                        c, id_valid, if_allowin, count, pc_out, inst_out, mq.size());
         end
`ifdef YSYX_040750_IFQ_PREDECODE_EN
         if (mq.size() != 0) begin
            checks++;
            if (is_ctrl !== model_ctrl(mq[0][31:0])) begin
               errors++;
               $display("FAIL random_ctrl%0d: is_ctrl=%b want %b", c, is_ctrl, model_ctrl(mq[0][31:0]));
            end
         end
`endif
         acc = (if_valid && if_allowin) || flush;
         tick();
         if (acc) if_valid = 0;
      end
      idle_inputs();
   endtask

`ifdef YSYX_040750_IFQ_PREDECODE_EN
   task automatic test_predecode();
      do_reset();
      if_valid = 1; pc_in = 32'h3000_0000; inst_in = 32'h0000_006F;
      tick();
      pc_in = 32'h3000_0004; inst_in = 32'h0000_0013;
      tick();
      if_valid = 0;
      checks++;
      if (is_ctrl !== 1'b1) begin
         errors++;
         $display("FAIL predecode_jal: is_ctrl=%b want 1", is_ctrl);
      end
      id_allowin = 1;
      tick();
      id_allowin = 0;
      checks++;
      if (is_ctrl !== 1'b0 || pc_out !== 32'h3000_0004) begin
         errors++;
         $display("FAIL predecode_nop: is_ctrl=%b pc=%h want 0 30000004", is_ctrl, pc_out);
      end
   endtask
`endif

   initial begin
      rst = 1;
      idle_inputs();
      test_reset();
      test_fill_stall();
      test_streaming();
      test_flush();
      test_flush_reset();
`ifdef YSYX_040750_IFQ_PREDECODE_EN
      test_predecode();
`endif
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end
endmodule
